// File: rtl/matrix_alu_param.sv
// matrix_alu_param: parametrised DIM x DIM signed matrix ALU (add/sub/mult/scale/transpose, wrap or saturate)
// Multiply produces one dot-product element per cycle; elementwise ops finish in a single EXEC cycle.
module matrix_alu_param #(
  parameter int DIM = 4,
  parameter int EW  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  readwrite,
  input  logic [7:0]            opcode,
  input  logic [DIM*DIM*EW-1:0] in,
  output logic [DIM*DIM*EW-1:0] out,
  output logic                  status,
  output logic                  done,
  output logic                  err
);
  localparam int BUS = DIM*DIM*EW;
  localparam int PW  = 2*EW + $clog2(DIM);
  localparam int IW  = $clog2(DIM*DIM);
  localparam logic signed [PW-1:0] MAXV = {{(PW-EW+1){1'b0}}, {(EW-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = {{(PW-EW+1){1'b1}}, {(EW-1){1'b0}}};
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  state_t r_state, w_next;
  logic [BUS-1:0] r_a, r_b, r_c, r_out, w_el;
  logic [2:0] r_op;
  logic r_sat, r_err;
  logic signed [EW-1:0] r_s;
  logic [IW-1:0] r_idx;
  logic signed [PW-1:0] w_dot;
  logic w_cmd, w_acc, w_busy, w_last;
  function automatic logic [EW-1:0] fit(input logic signed [PW-1:0] v, input logic sat);
    return !sat ? v[EW-1:0] : v > MAXV ? MAXV[EW-1:0] : v < MINV ? MINV[EW-1:0] : v[EW-1:0];
  endfunction
  assign w_busy = r_state == EXEC;
  assign w_cmd  = enable && !readwrite && opcode[7];
  assign w_acc  = w_cmd && !w_busy && opcode[2:0] != 3'd0 && opcode[2:0] <= 3'd5;
  assign w_last = r_op != 3'd3 || r_idx == IW'(DIM*DIM-1);
  assign status = w_busy;
  assign done   = r_state == DONE;
  assign err    = r_err;
  assign out    = r_out;
  always_comb begin
    w_next = IDLE;
    if (w_busy) w_next = w_last ? DONE : EXEC;
    else if (w_acc) w_next = EXEC;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Dot product of row idx/DIM of A with column idx%DIM of B
  always_comb begin
    w_dot = '0;
    for (int k = 0; k < DIM; k++)
      w_dot = w_dot + PW'($signed(r_a[(int'(r_idx) / DIM * DIM + k) * EW +: EW]))
                    * PW'($signed(r_b[(k * DIM + int'(r_idx) % DIM) * EW +: EW]));
  end
  for (genvar r = 0; r < DIM; r++) begin : g_r
    for (genvar c = 0; c < DIM; c++) begin : g_c
      logic signed [PW-1:0] w_a, w_b;
      assign w_a = PW'($signed(r_a[(r*DIM+c)*EW +: EW]));
      assign w_b = PW'($signed(r_b[(r*DIM+c)*EW +: EW]));
      assign w_el[(r*DIM+c)*EW +: EW] = r_op == 3'd5 ? r_a[(c*DIM+r)*EW +: EW]
        : fit(r_op == 3'd1 ? w_a + w_b : r_op == 3'd2 ? w_a - w_b : w_a * PW'(r_s), r_sat);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= '0;
      r_out <= '0;
      r_op  <= '0;
      r_sat <= 1'b0;
      r_s   <= '0;
      r_idx <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_cmd && !w_acc;
      if (enable && !readwrite && !w_busy && opcode == 8'h01) r_a <= in;
      if (enable && !readwrite && !w_busy && opcode == 8'h02) r_b <= in;
      if (enable && readwrite) r_out <= r_c;
      if (w_acc) begin
        r_op  <= opcode[2:0];
        r_sat <= opcode[6];
        r_s   <= in[EW-1:0];
        r_idx <= '0;
      end
      if (w_busy && r_op == 3'd3) begin
        r_c[int'(r_idx)*EW +: EW] <= fit(w_dot, r_sat);
        r_idx <= w_last ? '0 : r_idx + 1'b1;
      end else if (w_busy) r_c <= w_el;
    end
  end
endmodule

// File: tb/tb_matrix_alu_param.sv
// tb_matrix_alu_param: directed vectors; expected read results are queued and checked by a separate monitor
module tb_matrix_alu_param;
  localparam int DIM = 4;
  localparam int EW  = 16;
  localparam int BUS = DIM*DIM*EW;
  logic clk = 1'b0;
  logic reset, enable, readwrite, status, done, err;
  logic [7:0] opcode;
  logic [BUS-1:0] in, out;
  logic [BUS-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  matrix_alu_param #(.DIM(DIM), .EW(EW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .readwrite(readwrite), .opcode(opcode),
    .in(in), .out(out), .status(status), .done(done), .err(err)
  );
  function automatic logic [BUS-1:0] fill(input logic [EW-1:0] v);
    logic [BUS-1:0] m;
    for (int i = 0; i < DIM*DIM; i++) m[i*EW +: EW] = v;
    return m;
  endfunction
  function automatic logic [BUS-1:0] one_at(input int r, input int c, input logic [EW-1:0] v);
    logic [BUS-1:0] m;
    m = '0;
    m[(r*DIM+c)*EW +: EW] = v;
    return m;
  endfunction
  function automatic logic [BUS-1:0] ident();
    logic [BUS-1:0] m;
    m = '0;
    for (int i = 0; i < DIM; i++) m[(i*DIM+i)*EW +: EW] = 16'h0001;
    return m;
  endfunction
  function automatic logic [BUS-1:0] ramp();
    logic [BUS-1:0] m;
    for (int i = 0; i < DIM*DIM; i++) m[i*EW +: EW] = EW'(i);
    return m;
  endfunction
  task automatic chk(input string nm, input logic [BUS-1:0] act, input logic [BUS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask
  task automatic step(input logic en, input logic rw, input logic [7:0] op, input logic [BUS-1:0] d);
    enable = en;
    readwrite = rw;
    opcode = op;
    in = d;
    @(posedge clk);
    #1;
    enable = 1'b0;
    readwrite = 1'b0;
    opcode = 8'h00;
    in = '0;
  endtask
  task automatic rd(input logic [BUS-1:0] exp);
    exp_q.push_back(exp);
    step(1'b1, 1'b1, 8'h00, '0);
  endtask
  task automatic wait_idle(input string nm, input int busy);
    int n;
    n = 0;
    while (status === 1'b1 && n < 200) begin
      n++;
      @(posedge clk);
      #1;
    end
    chk({nm, "_busy_cycles"}, BUS'(n), BUS'(busy));
    chk({nm, "_done"}, BUS'(done), BUS'(1));
    @(posedge clk);
    #1;
    chk({nm, "_done_pulse"}, BUS'(done), BUS'(0));
  endtask
  task automatic run(input string nm, input logic [7:0] op, input logic [BUS-1:0] d, input int busy);
    step(1'b1, 1'b0, op, d);
    chk({nm, "_status"}, BUS'(status), BUS'(1));
    wait_idle(nm, busy);
  endtask
  initial begin : monitor
    logic [BUS-1:0] e;
    forever begin
      @(posedge clk);
      if (enable === 1'b1 && readwrite === 1'b1 && reset === 1'b0) begin
        #1;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL read_unexpected got=%h want=no read", out);
        end else begin
          e = exp_q.pop_front();
          if (out !== e) begin
            errors++;
            $display("FAIL read_out got=%h want=%h", out, e);
          end
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end
  initial begin
    logic ok;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      enable = 1'($urandom);
      readwrite = 1'($urandom);
      opcode = 8'($urandom);
      for (int j = 0; j < DIM*DIM; j++) in[j*EW +: EW] = 16'($urandom);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    enable = 1'b0;
    readwrite = 1'b0;
    opcode = 8'h00;
    in = '0;
    chk("rst_out", out, '0);
    chk("rst_status", BUS'(status), '0);
    chk("rst_done", BUS'(done), '0);
    chk("rst_err", BUS'(err), '0);
    rd('0);
    step(1'b1, 1'b0, 8'h01, fill(16'h0004));
    step(1'b1, 1'b0, 8'h02, fill(16'h0003));
    run("add", 8'h81, '0, 1);
    rd(fill(16'h0007));
    run("sub", 8'h82, '0, 1);
    rd(fill(16'h0001));
    step(1'b1, 1'b0, 8'h01, fill(16'h7FFF));
    step(1'b1, 1'b0, 8'h02, fill(16'h0001));
    run("add_wrap", 8'h81, '0, 1);
    rd(fill(16'h8000));
    run("add_sat", 8'hC1, '0, 1);
    rd(fill(16'h7FFF));
    step(1'b1, 1'b0, 8'h01, fill(16'h8000));
    run("sub_sat", 8'hC2, '0, 1);
    rd(fill(16'h8000));
    step(1'b1, 1'b0, 8'h01, ident());
    step(1'b1, 1'b0, 8'h02, ramp());
    run("mult_ident", 8'h83, '0, 16);
    rd(ramp());
    step(1'b1, 1'b0, 8'h01, fill(16'h0100));
    step(1'b1, 1'b0, 8'h02, fill(16'h0100));
    run("mult_sat", 8'hC3, '0, 16);
    rd(fill(16'h7FFF));
    run("mult_wrap", 8'h83, '0, 16);
    rd(fill(16'h0000));
    step(1'b1, 1'b0, 8'h01, one_at(0, 1, 16'h0002));
    run("transpose", 8'h85, '0, 1);
    rd(one_at(1, 0, 16'h0002));
    step(1'b1, 1'b0, 8'h01, fill(16'h0005));
    run("scale", 8'h84, BUS'(16'hFFFF), 1);
    rd(fill(16'hFFFB));
    step(1'b1, 1'b0, 8'h86, '0);
    chk("bad_op_err", BUS'(err), BUS'(1));
    chk("bad_op_status", BUS'(status), '0);
    step(1'b0, 1'b0, 8'h00, '0);
    chk("bad_op_err_pulse", BUS'(err), '0);
    step(1'b1, 1'b0, 8'h01, ident());
    step(1'b1, 1'b0, 8'h02, ramp());
    step(1'b1, 1'b0, 8'h83, '0);
    rd(fill(16'hFFFB));
    step(1'b1, 1'b0, 8'h01, fill(16'h0009));
    chk("busy_load_no_err", BUS'(err), '0);
    step(1'b1, 1'b0, 8'h81, '0);
    chk("busy_cmd_err", BUS'(err), BUS'(1));
    chk("busy_cmd_status", BUS'(status), BUS'(1));
    wait_idle("mult_busy_cmd", 13);
    rd(ramp());
    step(1'b1, 1'b0, 8'h83, '0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, '0);
    reset = 1'b1;
    step(1'b0, 1'b0, 8'h00, '0);
    reset = 1'b0;
    chk("abort_status", BUS'(status), '0);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (done !== 1'b0) ok = 1'b0;
      step(1'b0, 1'b0, 8'h00, '0);
    end
    chk("abort_no_done", BUS'(ok), BUS'(1));
    rd('0);
    step(1'b0, 1'b0, 8'h00, '0);
    chk("queue_drained", BUS'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
